seq_pattern_detector: RTL

- Parametrised successor to the team's fixed 4-bit Mealy sequence detector.
- Detects a runtime-programmable serial bit pattern of length 1..PAT_W on d_in.
- Supports overlapping or non-overlapping match modes and keeps a saturating match counter.
- Bit timing comes from a one-cycle bit strobe (bit_en) in the single clk domain, replacing a divided clock; sits between a serial bit source and status/interrupt logic.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_match_cmp.sv | 36 +++
 rtl/seq_pattern_detector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared FSM encoding, length clamp and default sizes for the
//                serial pattern detector family.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int c_PAT_W_DEFAULT = 8;
    localparam int c_CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HUNT = 2'b10
    } state_t;

    // Map a requested pattern length onto the supported range 1..max_len.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1)
            return 1;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_cmp
//  Description : Stateless masked compare of {history, current bit} against
//                the low i_len bits of a pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_cmp #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic [PAT_W-2:0] i_hist,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_match
);

    logic [PAT_W-1:0] w_window;
    logic [PAT_W-1:0] w_mask;

    // Bit 0 is the newest bit, so pattern bit k pairs with the bit seen k steps ago.
    assign w_window = {i_hist, i_bit};

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < PAT_W; k++) begin
            if (k < int'(i_len))
                w_mask[k] = 1'b1;
        end
    end

    assign o_match = (((w_window ^ i_pattern) & w_mask) == '0);

endmodule
`default_nettype wire

// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_detector
//  Description : Programmable serial pattern detector with overlap control and
//                saturating match counter. Define DETECT_REG_EN to register
//                the detected flag one clk after the matching bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = c_PAT_W_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bit_en,
    input  logic                         d_in,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         detected,
    output logic                         armed,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int               c_LEN_W    = $clog2(PAT_W + 1);
    localparam logic [c_LEN_W-1:0] c_FILL_MAX = c_LEN_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t               r_state;
    logic [PAT_W-2:0]     r_hist;
    logic [c_LEN_W-1:0]   r_fill;
    logic [PAT_W-1:0]     r_pattern;
    logic [c_LEN_W-1:0]   r_len;
    logic                 r_overlap;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_armed;

    logic [c_LEN_W-1:0]   w_len_clamped;
    logic [PAT_W-1:0]     w_shift;
    logic                 w_cmp;
    logic                 w_fill_ok;
    logic                 w_match;

    assign w_len_clamped = c_LEN_W'(clamp_len(int'(cfg_len), PAT_W));
    assign w_shift       = {r_hist, d_in};
    assign w_fill_ok     = (r_fill >= (r_len - c_LEN_W'(1)));

    seq_match_cmp #(
        .PAT_W (PAT_W),
        .LEN_W (c_LEN_W)
    ) u_cmp (
        .i_hist    (r_hist),
        .i_bit     (d_in),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .o_match   (w_cmp)
    );

    // A coincident cfg_load or reset swallows the bit, so it can never match.
    assign w_match = reset && (r_state == ST_HUNT) && bit_en && !cfg_load
                     && w_fill_ok && w_cmp;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_match && (r_cnt != c_CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);

            case (r_state)
                ST_IDLE, ST_HUNT: begin
                    if (cfg_load) begin
                        r_pattern <= cfg_pattern;
                        r_len     <= w_len_clamped;
                        r_overlap <= cfg_overlap;
                        r_hist    <= '0;
                        r_fill    <= '0;
                        r_state   <= ST_HUNT;
                        r_armed   <= 1'b1;
                    end else if ((r_state == ST_HUNT) && bit_en) begin
                        r_hist <= w_shift[PAT_W-2:0];
                        if (w_match && !r_overlap)
                            r_fill <= '0;
                        else if (r_fill != c_FILL_MAX)
                            r_fill <= r_fill + c_LEN_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_armed <= 1'b0;
                    r_hist  <= '0;
                    r_fill  <= '0;
                end
            endcase
        end
    end

`ifdef DETECT_REG_EN
    logic r_det;

    always_ff @(posedge clk) begin
        if (!reset)
            r_det <= 1'b0;
        else
            r_det <= w_match;
    end

    assign detected = r_det;
`else
    assign detected = w_match;
`endif

    assign armed     = r_armed;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire
